vx_dot8_commit_gather: RTL and testbench

Downstream of the DOT8 ALU's commit port: collects the partial-warp result packets (pid/sop/eop framed, NUM_LANES wide) that the DOT8 unit emits and reassembles them into one full-warp (NUM_THREADS wide) commit. The single full-warp commit goes to the writeback arbiter, so writeback sees one transaction per DOT8 instruction.

---
 rtl/VX_gpu_pkg.sv | 26 ++
 rtl/vx_gather_slot_buf.sv | 46 ++++
 rtl/vx_dot8_commit_gather.sv | 112 +++++++++++
 tb/tb_vx_dot8_commit_gather.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared types for the DOT8 commit gather: FSM state and the captured instruction header.
package VX_gpu_pkg;

  localparam int GATHER_NUM_LANES   = 2;
  localparam int GATHER_NUM_THREADS = 8;
  localparam int GATHER_XLEN        = 32;
  localparam int GATHER_NW_WIDTH    = 2;
  localparam int GATHER_UUID_WIDTH  = 44;
  localparam int GATHER_NR_BITS     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_FULL   = 2'd2
  } gather_state_t;

  // Header fields are sized from the package constants above.
  typedef struct packed {
    logic [GATHER_UUID_WIDTH-1:0] uuid;
    logic [GATHER_NW_WIDTH-1:0]   wid;
    logic [GATHER_XLEN-1:0]       pc;
    logic [GATHER_NR_BITS-1:0]    rd;
    logic                         wb;
  } gather_hdr_t;

endpackage

// File: rtl/vx_gather_slot_buf.sv
// Per-packet-slot data/mask storage for a full warp; a slot write beats the clear
// so a new instruction's first packet lands in an otherwise emptied buffer.
module vx_gather_slot_buf #(
  parameter int NUM_PKTS  = 4,
  parameter int NUM_LANES = 2,
  parameter int XLEN      = 32,
  parameter int PID_WIDTH = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            wr_en,
  input  logic [PID_WIDTH-1:0]            wr_pid,
  input  logic [NUM_LANES-1:0]            wr_tmask,
  input  logic [NUM_LANES*XLEN-1:0]       wr_data,
  output logic [NUM_PKTS*NUM_LANES-1:0]   tmask,
  output logic [NUM_PKTS*NUM_LANES*XLEN-1:0] data
);

  logic [NUM_PKTS-1:0] slot_we;

  always_comb begin
    slot_we = '0;
    for (int p = 0; p < NUM_PKTS; p++) begin
      slot_we[p] = wr_en && (wr_pid == PID_WIDTH'(p));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmask <= '0;
      data  <= '0;
    end else begin
      for (int p = 0; p < NUM_PKTS; p++) begin
        if (slot_we[p]) begin
          tmask[p*NUM_LANES +: NUM_LANES]           <= wr_tmask;
          data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] <= wr_data;
        end else if (clr) begin
          tmask[p*NUM_LANES +: NUM_LANES]           <= '0;
          data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/vx_dot8_commit_gather.sv
// Reassembles pid/sop/eop framed DOT8 result packets into one full-warp commit.
// Handshake: a beat transfers on a clock edge where valid & ready are both high; valid never drops before that.
module vx_dot8_commit_gather
  import VX_gpu_pkg::*;
#(
  parameter int NUM_LANES   = GATHER_NUM_LANES,
  parameter int NUM_THREADS = GATHER_NUM_THREADS,
  parameter int XLEN        = GATHER_XLEN,
  parameter int NW_WIDTH    = GATHER_NW_WIDTH,
  parameter int UUID_WIDTH  = GATHER_UUID_WIDTH,
  parameter int NR_BITS     = GATHER_NR_BITS,
  localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
  localparam int PID_WIDTH  = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [XLEN-1:0]             in_PC,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic                        in_wb,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [XLEN-1:0]             out_PC,
  output logic [NR_BITS-1:0]          out_rd,
  output logic                        out_wb,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        err,
  output gather_state_t               dbg_state
);

  gather_state_t       state_q;
  gather_hdr_t         hdr_q;
  logic [NUM_PKTS-1:0] seen_q;
  logic [NUM_PKTS-1:0] pid_oh;
  logic                accept;
  logic                start;
  logic                cont;

  always_comb begin
    pid_oh = '0;
    for (int p = 0; p < NUM_PKTS; p++) begin
      pid_oh[p] = (in_pid == PID_WIDTH'(p));
    end
  end

  assign in_ready = (state_q != ST_FULL) | out_ready;
  assign accept   = in_valid & in_ready;
  // A sop always (re)starts a warp; a FULL warp leaving this cycle frees the buffer.
  assign start    = accept & in_sop;
  assign cont     = accept & ~in_sop & (state_q == ST_GATHER) & (in_wid == hdr_q.wid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hdr_q   <= '0;
      seen_q  <= '0;
      err     <= 1'b0;
    end else begin
      if (start) begin
        hdr_q   <= '{uuid: in_uuid, wid: in_wid, pc: in_PC, rd: in_rd, wb: in_wb};
        seen_q  <= pid_oh;
        state_q <= in_eop ? ST_FULL : ST_GATHER;
        if (state_q == ST_GATHER) err <= 1'b1;
      end else if (cont) begin
        seen_q <= seen_q | pid_oh;
        if (|(seen_q & pid_oh)) err <= 1'b1;
        if (in_eop) state_q <= ST_FULL;
      end else begin
        // Any other accepted packet is dropped: no sop outside a gather, or wrong warp.
        if (accept) err <= 1'b1;
        if (state_q == ST_FULL && out_ready) state_q <= ST_IDLE;
      end
    end
  end

  vx_gather_slot_buf #(
    .NUM_PKTS (NUM_PKTS),
    .NUM_LANES(NUM_LANES),
    .XLEN     (XLEN),
    .PID_WIDTH(PID_WIDTH)
  ) u_slot_buf (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (start),
    .wr_en   (start | cont),
    .wr_pid  (in_pid),
    .wr_tmask(in_tmask),
    .wr_data (in_data),
    .tmask   (out_tmask),
    .data    (out_data)
  );

  assign out_valid = (state_q == ST_FULL);
  assign out_uuid  = hdr_q.uuid;
  assign out_wid   = hdr_q.wid;
  assign out_PC    = hdr_q.pc;
  assign out_rd    = hdr_q.rd;
  assign out_wb    = hdr_q.wb;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vx_dot8_commit_gather.sv
// Directed bench for vx_dot8_commit_gather: vector table for steady streaming plus hand sequences for corners.
module tb_vx_dot8_commit_gather;
  import VX_gpu_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_wb, in_sop, in_eop;
  logic [43:0]   in_uuid;
  logic [1:0]    in_wid, in_pid, in_tmask;
  logic [31:0]   in_PC;
  logic [5:0]    in_rd;
  logic [63:0]   in_data;
  logic          out_valid, out_ready, out_wb, err;
  logic [43:0]   out_uuid;
  logic [1:0]    out_wid;
  logic [31:0]   out_PC;
  logic [5:0]    out_rd;
  logic [7:0]    out_tmask;
  logic [255:0]  out_data;
  gather_state_t dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0]  exp_d [8];
  logic [7:0]   exp_tm;
  logic [1:0]   exp_wid;
  logic [265:0] exp_q[$];

  vx_dot8_commit_gather dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_PC(in_PC), .in_rd(in_rd), .in_wb(in_wb), .in_tmask(in_tmask), .in_pid(in_pid),
    .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
    .out_PC(out_PC), .out_rd(out_rd), .out_wb(out_wb), .out_tmask(out_tmask),
    .out_data(out_data), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive_raw(input logic [1:0] pid, input logic sop, input logic eop, input logic [1:0] wid,
                           input logic [1:0] tm, input logic [31:0] d0, input logic [31:0] d1);
    in_valid = 1'b1;
    in_pid   = pid;
    in_sop   = sop;
    in_eop   = eop;
    in_wid   = wid;
    in_tmask = tm;
    in_data  = {d1, d0};
    // Only the sop packet carries a meaningful header; the rest is junk that must be ignored.
    in_uuid  = sop ? (44'hA00 + 44'(wid)) : 44'hFFF_FFFF_FFFF;
    in_PC    = sop ? (32'h8000_0000 + 32'(wid)) : 32'hFFFF_FFFF;
    in_rd    = sop ? (6'd5 + 6'(wid)) : 6'h3F;
    in_wb    = sop;
  endtask

  task automatic drive_pkt(input logic [1:0] pid, input logic sop, input logic eop, input logic [1:0] wid,
                           input logic [31:0] base);
    drive_raw(pid, sop, eop, wid, 2'b11, base + 32'(2 * pid), base + 32'(2 * pid + 1));
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic clear_exp(input logic [1:0] wid);
    exp_tm  = '0;
    exp_wid = wid;
    for (int t = 0; t < 8; t++) exp_d[t] = '0;
  endtask

  task automatic set_slot(input int p, input logic [31:0] base);
    exp_tm[2*p +: 2] = 2'b11;
    exp_d[2*p]       = base + 32'(2 * p);
    exp_d[2*p+1]     = base + 32'(2 * p + 1);
  endtask

  function automatic logic [255:0] pack_exp();
    logic [255:0] v;
    for (int t = 0; t < 8; t++) v[t*32 +: 32] = exp_d[t];
    return v;
  endfunction

  task automatic push_exp();
    exp_q.push_back({exp_wid, exp_tm, pack_exp()});
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".out_valid"}, 272'(out_valid), 272'(1'b1));
    chk({tag, ".out_tmask"}, 272'(out_tmask), 272'(exp_tm));
    chk({tag, ".out_data"},  272'(out_data),  272'(pack_exp()));
    chk({tag, ".out_wid"},   272'(out_wid),   272'(exp_wid));
    chk({tag, ".out_uuid"},  272'(out_uuid),  272'(44'hA00 + 44'(exp_wid)));
    chk({tag, ".out_PC"},    272'(out_PC),    272'(32'h8000_0000 + 32'(exp_wid)));
    chk({tag, ".out_rd"},    272'(out_rd),    272'(6'd5 + 6'(exp_wid)));
    chk({tag, ".out_wb"},    272'(out_wb),    272'(1'b1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // scoreboard: every accepted full-warp commit must match the next expected one
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb.unexpected_commit", 272'(1), 272'(0));
      end else begin
        chk("sb.commit", 272'({out_wid, out_tmask, out_data}), 272'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic        sop;
    logic        eop;
    logic [1:0]  pid;
    logic [1:0]  wid;
    logic [31:0] base;
    logic        exp_rdy;
    logic        exp_valid;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // warp wid1 (data = thread index) then warp wid2 back-to-back, out_ready held high
    tbl[0] = '{1'b1, 1'b0, 2'd0, 2'd1, 32'h0,   1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 2'd1, 2'd1, 32'h0,   1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'd2, 2'd1, 32'h0,   1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'd3, 2'd1, 32'h0,   1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 2'd0, 2'd2, 32'h100, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2'd1, 2'd2, 32'h100, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 2'd2, 2'd2, 32'h100, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 2'd3, 2'd2, 32'h100, 1'b1, 1'b1};

    rst_n = 1'b0;
    out_ready = 1'b0;
    drive_idle();
    in_pid = '0; in_wid = '0; in_tmask = '0; in_data = '0;
    in_uuid = '0; in_PC = '0; in_rd = '0; in_wb = 1'b0;
    clear_exp(2'd0);
    tick();
    tick();
    chk("rst.out_valid", 272'(out_valid), 272'(0));
    chk("rst.in_ready",  272'(in_ready),  272'(1));
    chk("rst.out_tmask", 272'(out_tmask), 272'(0));
    chk("rst.out_data",  272'(out_data),  272'(0));
    chk("rst.header",    272'({out_uuid, out_wid, out_PC, out_rd, out_wb}), 272'(0));
    chk("rst.err",       272'(err),       272'(0));
    chk("rst.state",     272'(dbg_state), 272'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // table-driven streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_pkt(tbl[i].pid, tbl[i].sop, tbl[i].eop, tbl[i].wid, tbl[i].base);
      if (tbl[i].sop) clear_exp(tbl[i].wid);
      set_slot(int'(tbl[i].pid), tbl[i].base);
      if (tbl[i].eop) push_exp();
      #1;
      chk($sformatf("tbl%0d.in_ready", i), 272'(in_ready), 272'(tbl[i].exp_rdy));
      tick();
      chk($sformatf("tbl%0d.out_valid", i), 272'(out_valid), 272'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check_out($sformatf("tbl%0d", i));
    end
    drive_idle();
    tick();
    chk("tbl.drain_valid", 272'(out_valid), 272'(0));
    chk("tbl.drain_state", 272'(dbg_state), 272'(ST_IDLE));
    chk("tbl.err", 272'(err), 272'(0));

    // backpressure: hold FULL three cycles while the next sop waits
    out_ready = 1'b0;
    clear_exp(2'd1);
    for (int p = 0; p < 4; p++) begin
      drive_pkt(2'(p), p == 0, p == 3, 2'd1, 32'h200);
      set_slot(p, 32'h200);
      tick();
    end
    push_exp();
    check_out("bp.full");
    drive_pkt(2'd0, 1'b1, 1'b0, 2'd2, 32'h300);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp.hold%0d.in_ready", c), 272'(in_ready), 272'(0));
      tick();
      chk($sformatf("bp.hold%0d.data", c), 272'(out_data), 272'(pack_exp()));
      chk($sformatf("bp.hold%0d.valid", c), 272'(out_valid), 272'(1));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 272'(in_ready), 272'(1));
    tick();
    chk("bp.release.state", 272'(dbg_state), 272'(ST_GATHER));
    chk("bp.release.valid", 272'(out_valid), 272'(0));
    clear_exp(2'd2);
    set_slot(0, 32'h300);
    for (int p = 1; p < 4; p++) begin
      drive_pkt(2'(p), 1'b0, p == 3, 2'd2, 32'h300);
      set_slot(p, 32'h300);
      if (p == 3) push_exp();
      tick();
    end
    check_out("bp.second");
    drive_idle();
    tick();

    // sparse single-packet warp: only pid 2
    clear_exp(2'd3);
    exp_tm = 8'h30;
    exp_d[4] = 32'hAA;
    exp_d[5] = 32'hBB;
    push_exp();
    drive_raw(2'd2, 1'b1, 1'b1, 2'd3, 2'b11, 32'hAA, 32'hBB);
    tick();
    check_out("sparse");
    drive_idle();
    tick();
    chk("sparse.drain", 272'(out_valid), 272'(0));
    chk("sparse.err", 272'(err), 272'(0));

    // packet without sop in IDLE
    drive_pkt(2'd1, 1'b0, 1'b0, 2'd1, 32'h0);
    tick();
    drive_idle();
    chk("nosop.err", 272'(err), 272'(1));
    chk("nosop.state", 272'(dbg_state), 272'(ST_IDLE));
    tick();
    chk("nosop.valid", 272'(out_valid), 272'(0));
    chk("nosop.sticky", 272'(err), 272'(1));
    do_reset();
    chk("rst2.err", 272'(err), 272'(0));

    // wid mismatch mid-gather: wrong-warp eop is dropped
    clear_exp(2'd1);
    drive_pkt(2'd0, 1'b1, 1'b0, 2'd1, 32'h400);
    set_slot(0, 32'h400);
    tick();
    drive_raw(2'd3, 1'b0, 1'b1, 2'd3, 2'b11, 32'h777, 32'h777);
    tick();
    chk("widmm.state", 272'(dbg_state), 272'(ST_GATHER));
    chk("widmm.valid", 272'(out_valid), 272'(0));
    chk("widmm.err", 272'(err), 272'(1));
    for (int p = 1; p < 4; p++) begin
      drive_pkt(2'(p), 1'b0, p == 3, 2'd1, 32'h400);
      set_slot(p, 32'h400);
      if (p == 3) push_exp();
      tick();
    end
    check_out("widmm");
    drive_idle();
    tick();
    do_reset();

    // duplicate pid overwrites its slot and flags
    clear_exp(2'd2);
    drive_pkt(2'd0, 1'b1, 1'b0, 2'd2, 32'h900);
    tick();
    chk("dup.first_err", 272'(err), 272'(0));
    drive_pkt(2'd0, 1'b0, 1'b0, 2'd2, 32'hA00);
    set_slot(0, 32'hA00);
    tick();
    chk("dup.err", 272'(err), 272'(1));
    for (int p = 1; p < 4; p++) begin
      drive_pkt(2'(p), 1'b0, p == 3, 2'd2, 32'hA00);
      set_slot(p, 32'hA00);
      if (p == 3) push_exp();
      tick();
    end
    check_out("dup");
    drive_idle();
    tick();
    do_reset();

    // new sop mid-gather discards the partial warp
    drive_pkt(2'd0, 1'b1, 1'b0, 2'd1, 32'h500);
    tick();
    drive_pkt(2'd1, 1'b0, 1'b0, 2'd1, 32'h500);
    tick();
    clear_exp(2'd2);
    drive_pkt(2'd0, 1'b1, 1'b0, 2'd2, 32'h600);
    set_slot(0, 32'h600);
    tick();
    chk("resop.err", 272'(err), 272'(1));
    chk("resop.state", 272'(dbg_state), 272'(ST_GATHER));
    drive_pkt(2'd3, 1'b0, 1'b1, 2'd2, 32'h600);
    set_slot(3, 32'h600);
    push_exp();
    tick();
    check_out("resop");
    chk("resop.tmask_c3", 272'(out_tmask), 272'(8'hC3));
    drive_idle();
    tick();
    do_reset();

    // asynchronous reset mid-gather
    drive_pkt(2'd0, 1'b1, 1'b0, 2'd1, 32'h700);
    tick();
    drive_pkt(2'd1, 1'b0, 1'b0, 2'd1, 32'h700);
    tick();
    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 272'(out_valid), 272'(0));
    chk("arst.state", 272'(dbg_state), 272'(ST_IDLE));
    chk("arst.tmask", 272'(out_tmask), 272'(0));
    chk("arst.data", 272'(out_data), 272'(0));
    tick();
    rst_n = 1'b1;
    tick();
    clear_exp(2'd2);
    drive_pkt(2'd2, 1'b1, 1'b0, 2'd2, 32'h800);
    set_slot(2, 32'h800);
    tick();
    drive_pkt(2'd3, 1'b0, 1'b1, 2'd2, 32'h800);
    set_slot(3, 32'h800);
    push_exp();
    tick();
    check_out("arst.next");
    chk("arst.err", 272'(err), 272'(0));
    drive_idle();
    tick();
    tick();

    chk("sb.all_consumed", 272'(exp_q.size()), 272'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
